// File: rtl/posit_divsqrt_issuer.sv
// Issue controller for the PPU iterative posit divide/sqrt unit: accepts one
// valid/ready operation, starts the unit, buffers its result, flush/watchdog kill.
package posit_pkg;
  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } roundmode_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;
endpackage

module posit_divsqrt_issuer #(
  parameter int unsigned N           = 32,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RI,
  input  logic                 In_valid_SI,
  output logic                 In_ready_SO,
  input  logic                 In_op_SI,
  input  logic [N-1:0]         In_a_DI,
  input  logic [N-1:0]         In_b_DI,
  input  posit_pkg::roundmode_e In_rm_SI,
  input  logic [TAG_W-1:0]     In_tag_DI,
  output logic                 Div_start_SO,
  output logic                 Sqrt_start_SO,
  output logic [N-1:0]         Operand_a_DO,
  output logic [N-1:0]         Operand_b_DO,
  output posit_pkg::roundmode_e RM_SO,
  output logic [1:0]           Format_sel_SO,
  output logic                 Kill_SO,
  input  logic                 Ready_DI,
  input  logic                 Done_DI,
  input  logic [N-1:0]         Result_DI,
  input  posit_pkg::status_t   Fflags_DI,
  input  logic                 Flush_SI,
  output logic                 Out_valid_SO,
  input  logic                 Out_ready_SI,
  output logic [N-1:0]         Out_result_DO,
  output posit_pkg::status_t   Out_fflags_DO,
  output logic [TAG_W-1:0]     Out_tag_DO,
  output logic                 Out_timeout_SO
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, HOLD} state_e;

  state_e                state_q;
  logic                  op_q;
  logic [N-1:0]          a_q;
  logic [N-1:0]          b_q;
  posit_pkg::roundmode_e rm_q;
  logic [TAG_W-1:0]      tag_q;
  logic [N-1:0]          result_q;
  posit_pkg::status_t    fflags_q;
  logic                  timeout_q;
  logic [CNT_W-1:0]      cnt_q;

  logic in_ready;
  logic accept;
  logic start;
  logic timeout_hit;
  logic flush_kill;

  // Reset and flush both close the input port and suppress every strobe.
  always_comb begin
    in_ready    = 1'b0;
    start       = 1'b0;
    timeout_hit = 1'b0;
    flush_kill  = 1'b0;
    if (!Rst_RI) begin
      if (Flush_SI) begin
        flush_kill = (state_q == ISSUE) || (state_q == BUSY);
      end else begin
        in_ready    = (state_q == IDLE) || ((state_q == HOLD) && Out_ready_SI);
        start       = (state_q == ISSUE) && Ready_DI;
        timeout_hit = (state_q == BUSY) && !Done_DI && (cnt_q == CNT_LAST);
      end
    end
  end

  assign accept = in_ready && In_valid_SI;

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      rm_q      <= posit_pkg::RNE;
      tag_q     <= '0;
      result_q  <= '0;
      fflags_q  <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        op_q  <= In_op_SI;
        a_q   <= In_a_DI;
        b_q   <= In_b_DI;
        rm_q  <= In_rm_SI;
        tag_q <= In_tag_DI;
      end
      if (Flush_SI) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (accept) state_q <= ISSUE;
          ISSUE: begin
            if (Ready_DI) begin
              state_q <= BUSY;
              cnt_q   <= '0;
            end
          end
          BUSY: begin
            // Done takes precedence over a watchdog expiry in the same cycle.
            if (Done_DI) begin
              result_q  <= Result_DI;
              fflags_q  <= Fflags_DI;
              timeout_q <= 1'b0;
              state_q   <= HOLD;
            end else if (cnt_q == CNT_LAST) begin
              result_q  <= NAR;
              fflags_q  <= '{NV: 1'b1, default: 1'b0};
              timeout_q <= 1'b1;
              state_q   <= HOLD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          HOLD: if (Out_ready_SI) state_q <= accept ? ISSUE : IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign In_ready_SO    = in_ready;
  assign Div_start_SO   = start && !op_q;
  assign Sqrt_start_SO  = start && op_q;
  assign Kill_SO        = flush_kill || timeout_hit;
  assign Operand_a_DO   = a_q;
  assign Operand_b_DO   = b_q;
  assign RM_SO          = rm_q;
  assign Format_sel_SO  = 2'b00;
  assign Out_valid_SO   = !Rst_RI && (state_q == HOLD);
  assign Out_result_DO  = result_q;
  assign Out_fflags_DO  = fflags_q;
  assign Out_tag_DO     = tag_q;
  assign Out_timeout_SO = Out_valid_SO && timeout_q;

endmodule

// File: tb/tb_posit_divsqrt_issuer.sv
// Self-checking bench for posit_divsqrt_issuer with a latency-programmable
// divsqrt unit model; expectations derived from cycle arithmetic.
module tb_posit_divsqrt_issuer;
  import posit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, in_valid = 1'b0, in_op = 1'b0, ready = 1'b0, flush = 1'b0;
  logic        out_ready = 1'b0, valid_t = 1'b0, done_t = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  roundmode_e  in_rm = RNE;
  logic [3:0]  in_tag = '0;

  logic        in_ready, div_start, sqrt_start, kill, out_valid, out_timeout, done_m;
  logic [31:0] op_a, op_b, out_result, res_m;
  roundmode_e  rm_o;
  logic [1:0]  fsel;
  status_t     out_fflags, ff_m;
  logic [3:0]  out_tag;

  logic        in_ready_t, div_start_t, sqrt_start_t, kill_t, out_valid_t, out_timeout_t;
  logic [31:0] op_a_t, op_b_t, out_result_t;
  roundmode_e  rm_t;
  logic [1:0]  fsel_t;
  status_t     out_fflags_t;
  logic [3:0]  out_tag_t;

  localparam logic [31:0] RES_T = 32'h1357_9BDF;
  localparam status_t     FF_T  = 5'b00101;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] unit_res(input logic op, input logic [31:0] a, input logic [31:0] b);
    return op ? ((a >> 1) ^ 32'h0F0F_0F0F) : (a ^ {b[15:0], b[31:16]});
  endfunction

  function automatic status_t unit_flags(input logic op, input logic [31:0] a);
    return status_t'({op, a[3:0]});
  endfunction

  posit_divsqrt_issuer #(.N(32), .TAG_W(4), .TIMEOUT_CYC(64)) dut (
    .Clk_CI(clk), .Rst_RI(rst), .In_valid_SI(in_valid), .In_ready_SO(in_ready),
    .In_op_SI(in_op), .In_a_DI(in_a), .In_b_DI(in_b), .In_rm_SI(in_rm), .In_tag_DI(in_tag),
    .Div_start_SO(div_start), .Sqrt_start_SO(sqrt_start), .Operand_a_DO(op_a),
    .Operand_b_DO(op_b), .RM_SO(rm_o), .Format_sel_SO(fsel), .Kill_SO(kill),
    .Ready_DI(ready), .Done_DI(done_m), .Result_DI(res_m), .Fflags_DI(ff_m),
    .Flush_SI(flush), .Out_valid_SO(out_valid), .Out_ready_SI(out_ready),
    .Out_result_DO(out_result), .Out_fflags_DO(out_fflags), .Out_tag_DO(out_tag),
    .Out_timeout_SO(out_timeout)
  );

  posit_divsqrt_issuer #(.N(32), .TAG_W(4), .TIMEOUT_CYC(8)) dut_t (
    .Clk_CI(clk), .Rst_RI(rst), .In_valid_SI(valid_t), .In_ready_SO(in_ready_t),
    .In_op_SI(in_op), .In_a_DI(in_a), .In_b_DI(in_b), .In_rm_SI(in_rm), .In_tag_DI(in_tag),
    .Div_start_SO(div_start_t), .Sqrt_start_SO(sqrt_start_t), .Operand_a_DO(op_a_t),
    .Operand_b_DO(op_b_t), .RM_SO(rm_t), .Format_sel_SO(fsel_t), .Kill_SO(kill_t),
    .Ready_DI(ready), .Done_DI(done_t), .Result_DI(RES_T), .Fflags_DI(FF_T),
    .Flush_SI(flush), .Out_valid_SO(out_valid_t), .Out_ready_SI(out_ready),
    .Out_result_DO(out_result_t), .Out_fflags_DO(out_fflags_t), .Out_tag_DO(out_tag_t),
    .Out_timeout_SO(out_timeout_t)
  );

  // Unit model: Done arrives unit_lat cycles after the start strobe cycle.
  int unsigned unit_lat = 10;
  int unsigned rem = 0;
  logic        u_op = 1'b0;
  logic [31:0] u_a = '0, u_b = '0;
  always @(posedge clk) begin
    if (rst || kill) rem <= 0;
    else if (div_start || sqrt_start) begin
      rem <= unit_lat; u_op <= sqrt_start; u_a <= op_a; u_b <= op_b;
    end else if (rem != 0) rem <= rem - 1;
  end
  assign done_m = (rem == 1);
  assign res_m  = unit_res(u_op, u_a, u_b);
  assign ff_m   = unit_flags(u_op, u_a);

  task automatic start_req(input logic op, input logic [31:0] a, input logic [31:0] b,
                           input roundmode_e rm, input logic [3:0] tag, input logic with_or,
                           output logic acc);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rm = rm; in_tag = tag;
    out_ready = with_or; flush = 1'b0;
    #1 acc = in_ready;
    @(posedge clk);
  endtask

  task automatic collect(input int ready_wait, input logic [31:0] ea, input logic [31:0] eb,
                         input roundmode_e erm, output int strobe_cyc, output int n_div,
                         output int n_sqrt, output int n_kill, output int valid_cyc,
                         output logic unstable);
    strobe_cyc = -1; n_div = 0; n_sqrt = 0; n_kill = 0; valid_cyc = -1; unstable = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; ready = (c > ready_wait);
      #1;
      if (div_start) begin n_div++; strobe_cyc = c; end
      if (sqrt_start) begin n_sqrt++; strobe_cyc = c; end
      if (kill) n_kill++;
      if (out_valid) begin valid_cyc = c; break; end
      if (op_a !== ea || op_b !== eb || rm_o !== erm) unstable = 1'b1;
    end
  endtask

  task automatic release_out(input int delay);
    for (int k = 0; k < delay; k++) begin
      @(negedge clk); out_ready = 1'b0;
    end
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; ready = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({out_valid, in_ready, div_start, sqrt_start, kill, out_timeout} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 000000",
                         {out_valid, in_ready, div_start, sqrt_start, kill, out_timeout}); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if ({out_result, out_tag, op_a, fsel} !== '0) begin
      errors++; $display("FAIL reset_regs: result %h tag %h opa %h fsel %b expected zeros",
                         out_result, out_tag, op_a, fsel); end
  endtask

  task automatic test_divide();
    logic acc, uns; int sc, nd, ns, nk, vc;
    unit_lat = 10;
    start_req(1'b0, 32'h6B31C72A, 32'h48000000, RNE, 4'd3, 1'b0, acc);
    collect(0, 32'h6B31C72A, 32'h48000000, RNE, sc, nd, ns, nk, vc, uns);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL div_accept: got %b expected 1", acc); end
    checks++; if (sc !== 1 || nd !== 1 || ns !== 0) begin
      errors++; $display("FAIL div_strobe: cyc %0d div %0d sqrt %0d expected 1 1 0", sc, nd, ns); end
    checks++; if (vc !== 12) begin errors++; $display("FAIL div_latency: got %0d expected 12", vc); end
    checks++; if (out_result !== unit_res(1'b0, 32'h6B31C72A, 32'h48000000)) begin
      errors++; $display("FAIL div_result: got %h expected %h", out_result,
                         unit_res(1'b0, 32'h6B31C72A, 32'h48000000)); end
    checks++; if (out_tag !== 4'd3 || out_timeout !== 1'b0 || nk !== 0) begin
      errors++; $display("FAIL div_tag_timeout: tag %0d to %b kills %0d expected 3 0 0", out_tag, out_timeout, nk); end
    release_out(0);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL div_release: valid %b ready %b expected 0 1", out_valid, in_ready); end
  endtask

  task automatic test_sqrt();
    logic acc, uns; int sc, nd, ns, nk, vc; logic [31:0] b;
    b = $urandom; unit_lat = 7;
    start_req(1'b1, 32'h6B31C72A, b, RTZ, 4'd9, 1'b0, acc);
    collect(5, 32'h6B31C72A, b, RTZ, sc, nd, ns, nk, vc, uns);
    checks++; if (sc !== 6 || ns !== 1 || nd !== 0) begin
      errors++; $display("FAIL sqrt_strobe: cyc %0d sqrt %0d div %0d expected 6 1 0", sc, ns, nd); end
    checks++; if (vc !== 14) begin errors++; $display("FAIL sqrt_latency: got %0d expected 14", vc); end
    checks++; if (uns !== 1'b0) begin errors++; $display("FAIL sqrt_operands_stable: got %b expected 0", uns); end
    checks++; if (out_result !== unit_res(1'b1, 32'h6B31C72A, b) || out_fflags !== unit_flags(1'b1, 32'h6B31C72A)) begin
      errors++; $display("FAIL sqrt_result: got %h/%b expected %h/%b", out_result, out_fflags,
                         unit_res(1'b1, 32'h6B31C72A, b), unit_flags(1'b1, 32'h6B31C72A)); end
    release_out(0);
  endtask

  task automatic test_back_to_back();
    logic acc, uns; int sc, nd, ns, nk, vc; logic [31:0] a1, b1, a2, b2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom; unit_lat = 4;
    start_req(1'b0, a1, b1, RUP, 4'd5, 1'b0, acc);
    collect(0, a1, b1, RUP, sc, nd, ns, nk, vc, uns);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); out_ready = 1'b0; #1;
      checks++; if (out_valid !== 1'b1 || out_result !== unit_res(1'b0, a1, b1) || out_tag !== 4'd5 || in_ready !== 1'b0) begin
        errors++; $display("FAIL b2b_hold_stable: valid %b result %h tag %0d ready %b expected 1 %h 5 0",
                           out_valid, out_result, out_tag, in_ready, unit_res(1'b0, a1, b1)); end
    end
    start_req(1'b1, a2, b2, RMM, 4'd12, 1'b1, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", acc); end
    collect(0, a2, b2, RMM, sc, nd, ns, nk, vc, uns);
    checks++; if (sc !== 1 || ns !== 1 || vc !== 6) begin
      errors++; $display("FAIL b2b_second: strobe %0d sqrt %0d valid %0d expected 1 1 6", sc, ns, vc); end
    checks++; if (out_result !== unit_res(1'b1, a2, b2) || out_tag !== 4'd12) begin
      errors++; $display("FAIL b2b_result: got %h tag %0d expected %h 12", out_result, out_tag, unit_res(1'b1, a2, b2)); end
    release_out(0);
  endtask

  task automatic test_random();
    logic acc, uns, op; int sc, nd, ns, nk, vc, rw; logic [31:0] a, b; logic [3:0] tag; roundmode_e rm;
    for (int i = 0; i < 16; i++) begin
      op = 1'($urandom); a = $urandom; b = $urandom; tag = 4'($urandom);
      rm = roundmode_e'($urandom_range(0, 4)); rw = $urandom_range(0, 4);
      unit_lat = $urandom_range(1, 20);
      start_req(op, a, b, rm, tag, 1'b0, acc);
      collect(rw, a, b, rm, sc, nd, ns, nk, vc, uns);
      checks++; if (sc !== rw + 1 || (op ? ns : nd) !== 1 || (op ? nd : ns) !== 0 || nk !== 0) begin
        errors++; $display("FAIL rand_strobe[%0d]: cyc %0d div %0d sqrt %0d kill %0d expected cyc %0d op %b",
                           i, sc, nd, ns, nk, rw + 1, op); end
      checks++; if (vc !== rw + int'(unit_lat) + 2) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, vc, rw + int'(unit_lat) + 2); end
      checks++; if (out_result !== unit_res(op, a, b) || out_fflags !== unit_flags(op, a) || out_tag !== tag
                    || out_timeout !== 1'b0 || uns !== 1'b0) begin
        errors++; $display("FAIL rand_result[%0d]: got %h/%b/%0d/%b/%b expected %h/%b/%0d/0/0", i, out_result,
                           out_fflags, out_tag, out_timeout, uns, unit_res(op, a, b), unit_flags(op, a), tag); end
      release_out($urandom_range(0, 3));
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_release[%0d]: got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_timeout(input logic use_done);
    int kc, nk, sc, vc;
    kc = -1; nk = 0; sc = -1; vc = -1;
    @(negedge clk);
    valid_t = 1'b1; in_op = 1'b0; in_a = $urandom; in_b = $urandom; in_tag = 4'd7; ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      valid_t = 1'b0; done_t = (c == 1) || (use_done && c == 9);
      #1;
      if (kill_t) begin nk++; kc = c; end
      if (div_start_t) sc = c;
      if (out_valid_t) begin vc = c; break; end
    end
    done_t = 1'b0;
    checks++; if (sc !== 1 || vc !== 10) begin
      errors++; $display("FAIL timeout_timing[%b]: strobe %0d valid %0d expected 1 10", use_done, sc, vc); end
    checks++; if (nk !== (use_done ? 0 : 1) || (!use_done && kc !== 9)) begin
      errors++; $display("FAIL timeout_kill[%b]: count %0d cyc %0d expected %0d at 9", use_done, nk, kc, use_done ? 0 : 1); end
    checks++; if (out_result_t !== (use_done ? RES_T : 32'h8000_0000) || out_fflags_t !== (use_done ? FF_T : 5'b10000)
                  || out_timeout_t !== !use_done || out_tag_t !== 4'd7) begin
      errors++; $display("FAIL timeout_result[%b]: got %h/%b/%b/%0d", use_done, out_result_t, out_fflags_t,
                         out_timeout_t, out_tag_t); end
    release_out(0);
  endtask

  task automatic test_flush();
    logic acc, uns; int sc, nd, ns, nk, vc, bad; logic [31:0] a;
    a = $urandom; unit_lat = 30; bad = 0;
    start_req(1'b0, a, a, RNE, 4'd1, 1'b0, acc);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); in_valid = (c == 4); ready = 1'b1; flush = (c == 4); #1;
    end
    checks++; if (kill !== 1'b1 || in_ready !== 1'b0 || div_start !== 1'b0) begin
      errors++; $display("FAIL flush_busy_kill: kill %b ready %b start %b expected 1 0 0", kill, in_ready, div_start); end
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_busy_idle: got %b expected 1", in_ready); end
    repeat (40) begin @(negedge clk); #1; if (out_valid || kill) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL flush_busy_no_output: got %0d expected 0", bad); end
    start_req(1'b1, a, a, RNE, 4'd2, 1'b0, acc);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); in_valid = 1'b0; ready = (c == 3); flush = (c == 3); #1;
    end
    checks++; if (kill !== 1'b1 || div_start !== 1'b0 || sqrt_start !== 1'b0) begin
      errors++; $display("FAIL flush_issue_kill: kill %b div %b sqrt %b expected 1 0 0", kill, div_start, sqrt_start); end
    @(negedge clk); flush = 1'b0; bad = 0;
    repeat (20) begin @(negedge clk); #1; if (out_valid || sqrt_start) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL flush_issue_no_output: got %0d expected 0", bad); end
    unit_lat = 3;
    start_req(1'b0, a, 32'h1, RDN, 4'd4, 1'b0, acc);
    collect(0, a, 32'h1, RDN, sc, nd, ns, nk, vc, uns);
    @(negedge clk); flush = 1'b1; in_valid = 1'b1; #1;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_hold_cycle: valid %b ready %b expected 1 0", out_valid, in_ready); end
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_hold_drop: valid %b ready %b expected 0 1", out_valid, in_ready); end
    start_req(1'b0, ~a, a, RNE, 4'd6, 1'b0, acc);
    collect(0, ~a, a, RNE, sc, nd, ns, nk, vc, uns);
    checks++; if (vc !== 5 || out_result !== unit_res(1'b0, ~a, a) || out_tag !== 4'd6) begin
      errors++; $display("FAIL flush_next_req: valid %0d result %h tag %0d expected 5 %h 6", vc, out_result,
                         out_tag, unit_res(1'b0, ~a, a)); end
    release_out(0);
  endtask

  task automatic test_reset_mid();
    logic acc, uns; int sc, nd, ns, nk, vc;
    unit_lat = 30;
    start_req(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, RUP, 4'd15, 1'b0, acc);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); in_valid = 1'b0; ready = 1'b1; rst = (c == 5); #1;
    end
    checks++; if ({out_valid, in_ready, div_start, sqrt_start, kill, out_timeout} !== 6'b0) begin
      errors++; $display("FAIL rstmid_outputs: got %b expected 000000",
                         {out_valid, in_ready, div_start, sqrt_start, kill, out_timeout}); end
    @(negedge clk); #1;
    checks++; if ({out_result, out_tag, op_a, op_b} !== '0) begin
      errors++; $display("FAIL rstmid_regs: result %h tag %h a %h b %h expected zeros", out_result, out_tag, op_a, op_b); end
    rst = 1'b0; unit_lat = 10;
    start_req(1'b0, 32'h6B31C72A, 32'h48000000, RNE, 4'd3, 1'b0, acc);
    collect(0, 32'h6B31C72A, 32'h48000000, RNE, sc, nd, ns, nk, vc, uns);
    checks++; if (vc !== 12 || nd !== 1 || out_result !== unit_res(1'b0, 32'h6B31C72A, 32'h48000000) || out_tag !== 4'd3) begin
      errors++; $display("FAIL rstmid_fresh_div: valid %0d div %0d result %h tag %0d expected 12 1 %h 3", vc, nd,
                         out_result, out_tag, unit_res(1'b0, 32'h6B31C72A, 32'h48000000)); end
    release_out(0);
  endtask

  initial begin
    test_reset();
    test_divide();
    test_sqrt();
    test_back_to_back();
    test_random();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
